// File: rtl/sha256_ctrl_pkg.sv
// sha256_ctrl_pkg: shared constants and types for the SHA-256 Wishbone
// register front end (register offsets, bit positions, FSM states and
// word counts). No ports; imported by sha256_wb_ctrl.
package sha256_ctrl_pkg;

  // Register byte offsets within the 256-byte window
  localparam logic [7:0] OFF_CTRL     = 8'h00;
  localparam logic [7:0] OFF_STATUS   = 8'h04;
  localparam logic [7:0] OFF_BLKCNT   = 8'h08;
  localparam logic [7:0] OFF_MSG_BASE = 8'h40;
  localparam logic [7:0] OFF_DIG_BASE = 8'h80;

  // CTRL bit positions
  localparam int CTRL_START  = 0;
  localparam int CTRL_INIT   = 1;
  localparam int CTRL_IRQ_EN = 2;

  // STATUS bit positions
  localparam int STATUS_BUSY = 0;
  localparam int STATUS_DONE = 1;

  localparam int MSG_WORDS = 16;
  localparam int DIG_WORDS = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_t;

  // 0x40..0x7C
  function automatic logic is_msg_addr(input logic [7:0] addr);
    return addr[7:6] == OFF_MSG_BASE[7:6];
  endfunction

  // 0x80..0x9C
  function automatic logic is_dig_addr(input logic [7:0] addr);
    return addr[7:5] == OFF_DIG_BASE[7:5];
  endfunction

endpackage

// File: rtl/sha256_wb_ctrl_wb_slave_if.sv
// wb_slave_if: Wishbone classic slave front end. Decodes the base address,
// generates a registered single-cycle ack and presents each accepted
// transfer as a one-cycle register strobe.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   stb, cyc, we, sel    Wishbone request qualifiers
//   wdata, adr           Wishbone write data and byte address
//   ack, rdata           Wishbone ack and read data (rdata is 0 outside ack)
//   reg_we / reg_re      one-cycle write / read strobe in the request cycle
//   reg_addr             word-aligned offset (adr[7:2], low bits zero)
//   reg_wdata, reg_be    write data and byte-lane write enables
//   reg_rdata            register read value for reg_addr (sampled on reg_re)
//
// Handshake: a request is accepted in any cycle where stb & cyc are high,
// the address hits this block and ack is low. The register side acts on it
// in that same cycle and ack follows exactly one cycle later for one cycle.
// Because ack masks acceptance, a stb held high through the ack cycle is
// treated as a fresh request only in the cycle after ack.
module wb_slave_if #(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stb,
  input  logic        cyc,
  input  logic        we,
  input  logic [3:0]  sel,
  input  logic [31:0] wdata,
  input  logic [31:0] adr,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        reg_we,
  output logic        reg_re,
  output logic [7:0]  reg_addr,
  output logic [31:0] reg_wdata,
  output logic [3:0]  reg_be,
  input  logic [31:0] reg_rdata
);

  logic req;
  logic unused_adr;

  assign req       = stb & cyc & ~ack & (adr[31:8] == BASE_ADR[31:8]);
  assign reg_we    = req & we;
  assign reg_re    = req & ~we;
  assign reg_addr  = {adr[7:2], 2'b00};
  assign reg_wdata = wdata;
  assign reg_be    = sel & {4{req & we}};

  // Byte offset within a word carries no meaning here
  assign unused_adr = &{1'b0, adr[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack   <= 1'b0;
      rdata <= 32'h0;
    end else begin
      ack   <= req;
      rdata <= reg_re ? reg_rdata : 32'h0;
    end
  end

endmodule

// File: rtl/sha256_wb_ctrl.sv
// sha256_wb_ctrl: register front end for the SHA-256 compression core.
// Firmware loads a 512-bit block into MSG0..15, writes CTRL.START, and the
// block launches the core, captures the digest into DIG0..7, sets
// STATUS.DONE, increments BLKCNT and raises irq_o when enabled.
//
// Ports:
//   wb_clk_i, wb_rst_ni        clock, async active-low reset
//   wbs_*                      Wishbone slave port
//   core_start_o               one-cycle launch pulse
//   core_init_o                1 = start from IV, 0 = chain previous digest
//   core_block_o               message block, MSG0 on [511:480]
//   core_ready_i               core can accept a start
//   core_digest_valid_i        one-cycle digest strobe
//   core_digest_i              digest, H0 on [255:224]
//   irq_o                      level interrupt, DONE & IRQ_EN registered
//   dbg_state                  current FSM state (IDLE/LAUNCH/WAIT)
module sha256_wb_ctrl
  import sha256_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int          DIG_W    = 256
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_dat_i,
  input  logic [31:0]      wbs_adr_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  output logic             core_start_o,
  output logic             core_init_o,
  output logic [511:0]     core_block_o,
  input  logic             core_ready_i,
  input  logic             core_digest_valid_i,
  input  logic [DIG_W-1:0] core_digest_i,
  output logic             irq_o,
  output logic [1:0]       dbg_state
);

  logic        reg_we;
  logic        reg_re;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_be;
  logic [31:0] reg_rdata;
  logic [31:0] rd_mux;

  state_t      state;
  logic        busy;
  logic        init_q;
  logic        irq_en_q;
  logic        done_q;
  logic [31:0] blkcnt;
  logic [31:0] msg [MSG_WORDS];
  logic [31:0] dig [DIG_WORDS];

  logic        ctrl_wr;
  logic        start_wr;
  logic        done_clr;
  logic        msg_wr;

  wb_slave_if #(
    .BASE_ADR (BASE_ADR)
  ) u_wb_slave_if (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_ni),
    .stb       (wbs_stb_i),
    .cyc       (wbs_cyc_i),
    .we        (wbs_we_i),
    .sel       (wbs_sel_i),
    .wdata     (wbs_dat_i),
    .adr       (wbs_adr_i),
    .ack       (wbs_ack_o),
    .rdata     (wbs_dat_o),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_be    (reg_be),
    .reg_rdata (reg_rdata)
  );

  assign busy      = (state != IDLE);
  assign dbg_state = state;

  assign ctrl_wr  = reg_we & (reg_addr == OFF_CTRL);
  assign start_wr = ctrl_wr & reg_wdata[CTRL_START];
  assign done_clr = reg_we & (reg_addr == OFF_STATUS) & reg_wdata[STATUS_DONE];
  assign msg_wr   = reg_we & is_msg_addr(reg_addr);

  assign core_init_o = init_q;

  for (genvar g = 0; g < MSG_WORDS; g++) begin : g_block
    assign core_block_o[511-32*g -: 32] = msg[g];
  end

  // Configuration and message storage. MSG and INIT are frozen while busy
  // so the core sees a stable block for the whole hash; IRQ_EN stays live.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      init_q   <= 1'b0;
      irq_en_q <= 1'b0;
      for (int i = 0; i < MSG_WORDS; i++) msg[i] <= 32'h0;
    end else begin
      if (ctrl_wr) begin
        irq_en_q <= reg_wdata[CTRL_IRQ_EN];
        if (!busy) init_q <= reg_wdata[CTRL_INIT];
      end
      if (msg_wr && !busy) begin
        for (int b = 0; b < 4; b++) begin
          if (reg_be[b]) msg[reg_addr[5:2]][8*b +: 8] <= reg_wdata[8*b +: 8];
        end
      end
    end
  end

  // Control FSM with its registered outputs, DONE, BLKCNT and digest.
  // A digest strobe only matters in WAIT; DONE set beats a same-cycle clear.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state        <= IDLE;
      core_start_o <= 1'b0;
      done_q       <= 1'b0;
      blkcnt       <= 32'h0;
      irq_o        <= 1'b0;
      for (int i = 0; i < DIG_WORDS; i++) dig[i] <= 32'h0;
    end else begin
      core_start_o <= 1'b0;
      irq_o        <= done_q & irq_en_q;
      if (done_clr) done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start_wr) state <= LAUNCH;
        end
        LAUNCH: begin
          if (core_ready_i) begin
            core_start_o <= 1'b1;
            state        <= WAIT;
          end
        end
        WAIT: begin
          if (core_digest_valid_i) begin
            for (int i = 0; i < DIG_WORDS; i++) begin
              dig[i] <= core_digest_i[DIG_W-1-32*i -: 32];
            end
            done_q <= 1'b1;
            blkcnt <= blkcnt + 32'd1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read mux; only driven during a read strobe so write cycles return 0
  always_comb begin
    rd_mux = 32'h0;
    if (reg_addr == OFF_CTRL) begin
      rd_mux[CTRL_INIT]   = init_q;
      rd_mux[CTRL_IRQ_EN] = irq_en_q;
    end else if (reg_addr == OFF_STATUS) begin
      rd_mux[STATUS_BUSY] = busy;
      rd_mux[STATUS_DONE] = done_q;
    end else if (reg_addr == OFF_BLKCNT) begin
      rd_mux = blkcnt;
    end else if (is_msg_addr(reg_addr)) begin
      rd_mux = msg[reg_addr[5:2]];
    end else if (is_dig_addr(reg_addr)) begin
      rd_mux = dig[reg_addr[4:2]];
    end
    reg_rdata = reg_re ? rd_mux : 32'h0;
  end

endmodule

// File: tb/tb_sha256_wb_ctrl.sv
// tb_sha256_wb_ctrl: self-checking bench for sha256_wb_ctrl. The bench plays
// both the Wishbone master and the SHA-256 core; expected register contents
// come from a behavioural model of the register map kept in this file.
module tb_sha256_wb_ctrl;

  localparam logic [31:0]  BASE    = 32'h3000_0000;
  localparam logic [255:0] ABC_DIG = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

  logic         clk = 1'b0;
  logic         wb_rst_ni = 1'b0;
  logic         wbs_stb_i = 1'b0;
  logic         wbs_cyc_i = 1'b0;
  logic         wbs_we_i = 1'b0;
  logic [3:0]   wbs_sel_i = 4'h0;
  logic [31:0]  wbs_dat_i = 32'h0;
  logic [31:0]  wbs_adr_i = 32'h0;
  logic         wbs_ack_o;
  logic [31:0]  wbs_dat_o;
  logic         core_start_o;
  logic         core_init_o;
  logic [511:0] core_block_o;
  logic         core_ready_i = 1'b1;
  logic         core_digest_valid_i = 1'b0;
  logic [255:0] core_digest_i = 256'h0;
  logic         irq_o;
  logic [1:0]   dbg_state;

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;

  // Reference model of the programmer-visible state
  logic [31:0] m_msg [16];
  logic [31:0] m_dig [8];
  logic [31:0] m_blkcnt;
  logic        m_init, m_irq_en, m_done, m_busy;

  always #5 clk = ~clk;

  // Counts start pulses seen in completed cycles
  always @(posedge clk) if (core_start_o === 1'b1) start_cnt++;

  sha256_wb_ctrl dut (
    .wb_clk_i            (clk),
    .wb_rst_ni           (wb_rst_ni),
    .wbs_stb_i           (wbs_stb_i),
    .wbs_cyc_i           (wbs_cyc_i),
    .wbs_we_i            (wbs_we_i),
    .wbs_sel_i           (wbs_sel_i),
    .wbs_dat_i           (wbs_dat_i),
    .wbs_adr_i           (wbs_adr_i),
    .wbs_ack_o           (wbs_ack_o),
    .wbs_dat_o           (wbs_dat_o),
    .core_start_o        (core_start_o),
    .core_init_o         (core_init_o),
    .core_block_o        (core_block_o),
    .core_ready_i        (core_ready_i),
    .core_digest_valid_i (core_digest_valid_i),
    .core_digest_i       (core_digest_i),
    .irq_o               (irq_o),
    .dbg_state           (dbg_state)
  );

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_msg[i] = 32'h0;
    for (int i = 0; i < 8; i++) m_dig[i] = 32'h0;
    m_blkcnt = 32'h0;
    m_init = 1'b0; m_irq_en = 1'b0; m_done = 1'b0; m_busy = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input logic [7:0] off);
    logic [7:0] o;
    o = {off[7:2], 2'b00};
    if (o == 8'h00) return {29'b0, m_irq_en, m_init, 1'b0};
    if (o == 8'h04) return {30'b0, m_done, m_busy};
    if (o == 8'h08) return m_blkcnt;
    if (o >= 8'h40 && o <= 8'h7C) return m_msg[int'((o - 8'h40) >> 2)];
    if (o >= 8'h80 && o <= 8'h9C) return m_dig[int'((o - 8'h80) >> 2)];
    return 32'h0;
  endfunction

  task automatic model_write(input logic [7:0] off, input logic [31:0] dat, input logic [3:0] sel);
    logic [7:0] o;
    o = {off[7:2], 2'b00};
    if (o == 8'h00) begin
      if (!m_busy) m_init = dat[1];
      m_irq_en = dat[2];
      if (dat[0] && !m_busy) m_busy = 1'b1;
    end else if (o == 8'h04) begin
      if (dat[1]) m_done = 1'b0;
    end else if (o >= 8'h40 && o <= 8'h7C && !m_busy) begin
      for (int b = 0; b < 4; b++)
        if (sel[b]) m_msg[int'((o - 8'h40) >> 2)][8*b +: 8] = dat[8*b +: 8];
    end
  endtask

  // A digest only lands while a hash is outstanding
  task automatic model_capture(input logic [255:0] dg);
    if (m_busy) begin
      for (int i = 0; i < 8; i++) m_dig[i] = dg[255-32*i -: 32];
      m_done = 1'b1;
      m_blkcnt = m_blkcnt + 32'd1;
      m_busy = 1'b0;
    end
  endtask

  function automatic logic [511:0] model_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[511-32*i -: 32] = m_msg[i];
    return b;
  endfunction

  function automatic logic [255:0] rand_dig();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  // ---------------- drivers (start and end just after a negedge) ----------------
  task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rd);
    int lat;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (wbs_ack_o !== 1'b1 && lat < 4);
    rd = wbs_dat_o;
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL ack_latency adr=%h got %0d cycles, required 1", adr, lat);
    end
    @(negedge clk);
  endtask

  task automatic wb_write(input logic [7:0] off, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] rd;
    wb_xfer(BASE | {24'h0, off}, 1'b1, dat, sel, rd);
    model_write(off, dat, sel);
  endtask

  task automatic wb_read(input logic [7:0] off, output logic [31:0] rd);
    wb_xfer(BASE | {24'h0, off}, 1'b0, 32'h0, 4'hF, rd);
  endtask

  task automatic apply_reset();
    wb_rst_ni = 1'b0;
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    core_ready_i = 1'b1; core_digest_valid_i = 1'b0; core_digest_i = 256'h0;
    repeat (3) @(negedge clk);
    wb_rst_ni = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  // Write CTRL with START and drive the core side until the launch pulse
  task automatic launch(input bit init, input bit irq_en, input int stall);
    logic [31:0] rd;
    int s0;
    core_ready_i = (stall == 0);
    s0 = start_cnt;
    wb_write(8'h00, {29'b0, irq_en, init, 1'b1}, 4'hF);
    if (stall > 0) begin
      wb_read(8'h04, rd);
      checks++;
      if (rd !== model_read(8'h04)) begin
        errors++; $display("FAIL stall_status got %h required %h", rd, model_read(8'h04));
      end
      repeat (stall - 2) @(negedge clk);
      checks++;
      if (start_cnt != s0 || core_start_o !== 1'b0) begin
        errors++; $display("FAIL stall_no_start got %0d pulses required 0", start_cnt - s0);
      end
      core_ready_i = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (core_start_o !== 1'b1) begin
      errors++; $display("FAIL start_pulse got %b required 1", core_start_o);
    end
    checks++;
    if (core_init_o !== m_init) begin
      errors++; $display("FAIL core_init got %b required %b", core_init_o, m_init);
    end
    checks++;
    if (core_block_o !== model_block()) begin
      errors++; $display("FAIL core_block got %h required %h", core_block_o, model_block());
    end
    @(negedge clk);
    checks++;
    if (core_start_o !== 1'b0 || start_cnt != s0 + 1) begin
      errors++; $display("FAIL start_width got %b/%0d pulses required 0/1", core_start_o, start_cnt - s0);
    end
  endtask

  // Return a digest from the core and check the interrupt a cycle later
  task automatic finish(input logic [255:0] dg);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    core_digest_valid_i = 1'b1; core_digest_i = dg;
    @(negedge clk);
    core_digest_valid_i = 1'b0; core_digest_i = ~dg;
    model_capture(dg);
    @(negedge clk);
    checks++;
    if (irq_o !== (m_done & m_irq_en)) begin
      errors++; $display("FAIL irq got %b required %b", irq_o, m_done & m_irq_en);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] rd;
    logic [7:0] offs [5];
    offs = '{8'h00, 8'h04, 8'h08, 8'h40, 8'h80};
    apply_reset();
    checks++;
    if (irq_o !== 1'b0 || core_start_o !== 1'b0 || wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'h0) begin
      errors++; $display("FAIL reset_outputs got irq=%b start=%b ack=%b dat=%h required all 0",
                         irq_o, core_start_o, wbs_ack_o, wbs_dat_o);
    end
    foreach (offs[i]) begin
      wb_read(offs[i], rd);
      checks++;
      if (rd !== 32'h0 || rd !== model_read(offs[i])) begin
        errors++; $display("FAIL reset_read off=%h got %h required 0", offs[i], rd);
      end
    end
  endtask

  task automatic test_abc();
    logic [31:0] rd;
    for (int i = 0; i < 16; i++)
      wb_write(8'h40 + 8'(4*i), (i == 0) ? 32'h61626380 : (i == 15) ? 32'h00000018 : 32'h0, 4'hF);
    launch(1'b1, 1'b1, 0);
    finish(ABC_DIG);
    wb_read(8'h80, rd);
    checks++;
    if (rd !== 32'hBA7816BF) begin errors++; $display("FAIL abc_dig0 got %h required BA7816BF", rd); end
    wb_read(8'h9C, rd);
    checks++;
    if (rd !== 32'hF20015AD) begin errors++; $display("FAIL abc_dig7 got %h required F20015AD", rd); end
    for (int i = 1; i < 7; i++) begin
      wb_read(8'h80 + 8'(4*i), rd);
      checks++;
      if (rd !== m_dig[i]) begin errors++; $display("FAIL abc_dig%0d got %h required %h", i, rd, m_dig[i]); end
    end
    wb_read(8'h04, rd);
    checks++;
    if (rd !== 32'h2) begin errors++; $display("FAIL abc_status got %h required 2", rd); end
    wb_read(8'h08, rd);
    checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL abc_blkcnt got %h required 1", rd); end
    checks++;
    if (irq_o !== 1'b1) begin errors++; $display("FAIL abc_irq got %b required 1", irq_o); end
  endtask

  task automatic test_busy();
    logic [31:0] rd;
    int s0;
    launch(1'b0, 1'b1, 0);
    s0 = start_cnt;
    wb_write(8'h4C, 32'hDEADBEEF, 4'hF);
    wb_write(8'h00, 32'h1, 4'hF);
    repeat (3) @(negedge clk);
    checks++;
    if (start_cnt != s0) begin errors++; $display("FAIL busy_restart got %0d pulses required 0", start_cnt - s0); end
    wb_read(8'h4C, rd);
    checks++;
    if (rd !== model_read(8'h4C)) begin errors++; $display("FAIL busy_msg3 got %h required %h", rd, model_read(8'h4C)); end
    wb_read(8'h04, rd);
    checks++;
    if (rd !== model_read(8'h04) || rd[0] !== 1'b1) begin
      errors++; $display("FAIL busy_status got %h required %h", rd, model_read(8'h04));
    end
    wb_read(8'h00, rd);
    checks++;
    if (rd !== model_read(8'h00)) begin errors++; $display("FAIL busy_ctrl got %h required %h", rd, model_read(8'h00)); end
    finish(rand_dig());
  endtask

  task automatic test_ready_stall();
    logic [31:0] rd;
    launch(1'b1, 1'b1, 10);
    finish(rand_dig());
    wb_read(8'h08, rd);
    checks++;
    if (rd !== m_blkcnt) begin errors++; $display("FAIL stall_blkcnt got %h required %h", rd, m_blkcnt); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd;
    logic [7:0] off;
    wb_write(8'h44, 32'h0, 4'hF);
    wb_write(8'h44, 32'hAABBCCDD, 4'b0101);
    wb_read(8'h44, rd);
    checks++;
    if (rd !== 32'h00BB00DD) begin errors++; $display("FAIL byte_lane_msg1 got %h required 00BB00DD", rd); end
    for (int i = 0; i < 24; i++) begin
      off = 8'h40 + 8'(4 * $urandom_range(0, 15));
      wb_write(off, $urandom, 4'($urandom_range(0, 15)));
    end
    for (int i = 0; i < 16; i++) begin
      off = 8'h40 + 8'(4*i);
      wb_read(off, rd);
      checks++;
      if (rd !== model_read(off)) begin errors++; $display("FAIL rand_msg%0d got %h required %h", i, rd, model_read(off)); end
    end
  endtask

  task automatic test_done_collision();
    logic [31:0] rd;
    logic [255:0] dg;
    dg = rand_dig();
    launch(1'b0, 1'b1, 0);
    // W1C DONE request in the very cycle the digest arrives
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b1; wbs_sel_i = 4'hF;
    wbs_adr_i = BASE | 32'h4; wbs_dat_i = 32'h2;
    core_digest_valid_i = 1'b1; core_digest_i = dg;
    @(negedge clk);
    checks++;
    if (wbs_ack_o !== 1'b1) begin errors++; $display("FAIL collide_ack got %b required 1", wbs_ack_o); end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0; core_digest_valid_i = 1'b0;
    model_capture(dg);
    @(negedge clk);
    wb_read(8'h04, rd);
    checks++;
    if (rd !== 32'h2 || rd !== model_read(8'h04)) begin errors++; $display("FAIL collide_done got %h required 2", rd); end
    wb_write(8'h04, 32'h2, 4'hF);
    wb_read(8'h04, rd);
    checks++;
    if (rd !== model_read(8'h04)) begin errors++; $display("FAIL w1c_done got %h required %h", rd, model_read(8'h04)); end
    checks++;
    if (irq_o !== 1'b0) begin errors++; $display("FAIL w1c_irq got %b required 0", irq_o); end
  endtask

  task automatic test_reset_mid_hash();
    logic [31:0] rd;
    logic [255:0] dg;
    logic [7:0] offs [6];
    offs = '{8'h00, 8'h04, 8'h08, 8'h40, 8'h80, 8'h9C};
    launch(1'b1, 1'b1, 0);
    #2 wb_rst_ni = 1'b0;
    #1;
    checks++;
    if (core_block_o !== 512'h0 || core_init_o !== 1'b0 || irq_o !== 1'b0) begin
      errors++; $display("FAIL async_reset got init=%b irq=%b block_nonzero=%b required 0",
                         core_init_o, irq_o, |core_block_o);
    end
    @(negedge clk);
    @(negedge clk);
    wb_rst_ni = 1'b1;
    model_reset();
    @(negedge clk);
    dg = rand_dig();
    core_digest_valid_i = 1'b1; core_digest_i = dg;
    @(negedge clk);
    core_digest_valid_i = 1'b0;
    model_capture(dg);
    @(negedge clk);
    foreach (offs[i]) begin
      wb_read(offs[i], rd);
      checks++;
      if (rd !== model_read(offs[i])) begin
        errors++; $display("FAIL midreset_read off=%h got %h required %h", offs[i], rd, model_read(offs[i]));
      end
    end
  endtask

  task automatic test_blkcnt_wrap();
    logic [31:0] rd;
    force dut.blkcnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.blkcnt;
    m_blkcnt = 32'hFFFF_FFFF;
    wb_read(8'h08, rd);
    checks++;
    if (rd !== m_blkcnt) begin errors++; $display("FAIL wrap_preset got %h required %h", rd, m_blkcnt); end
    launch(1'b1, 1'b0, 0);
    finish(rand_dig());
    wb_read(8'h08, rd);
    checks++;
    if (rd !== 32'h0 || rd !== m_blkcnt) begin errors++; $display("FAIL wrap_blkcnt got %h required 0", rd); end
  endtask

  task automatic test_decode();
    logic [31:0] rd;
    logic [7:0] offs [6];
    bit seen;
    bit pat [3];
    offs = '{8'h0C, 8'h3C, 8'hA0, 8'hFC, 8'h08, 8'h84};
    // Foreign base address and missing cyc must never be acked
    for (int k = 0; k < 2; k++) begin
      wbs_stb_i = 1'b1; wbs_cyc_i = (k == 1) ? 1'b0 : 1'b1; wbs_we_i = 1'b0;
      wbs_adr_i = (k == 0) ? 32'h3000_0100 : BASE;
      seen = 1'b0;
      repeat (3) begin @(negedge clk); if (wbs_ack_o === 1'b1) seen = 1'b1; end
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
      @(negedge clk);
      checks++;
      if (seen) begin errors++; $display("FAIL no_select_ack case=%0d got ack required none", k); end
    end
    // Held strobe: ack, gap, ack
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_adr_i = BASE | 32'h8;
    for (int i = 0; i < 3; i++) begin @(negedge clk); pat[i] = wbs_ack_o; end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    @(negedge clk);
    checks++;
    if (pat[0] !== 1'b1 || pat[1] !== 1'b0 || pat[2] !== 1'b1) begin
      errors++; $display("FAIL held_stb_ack got %b%b%b required 101", pat[0], pat[1], pat[2]);
    end
    // Unmapped and read-only offsets ignore writes
    foreach (offs[i]) begin
      wb_write(offs[i], $urandom, 4'hF);
      wb_read(offs[i], rd);
      checks++;
      if (rd !== model_read(offs[i])) begin
        errors++; $display("FAIL ro_unmapped off=%h got %h required %h", offs[i], rd, model_read(offs[i]));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 16; i++) wb_write(8'h40 + 8'(4*i), $urandom, 4'hF);
      if ($urandom_range(0, 1) == 1) wb_write(8'h04, 32'h2, 4'hF);
      launch(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(2, 5));
      finish(rand_dig());
      for (int i = 0; i < 8; i++) begin
        wb_read(8'h80 + 8'(4*i), rd);
        checks++;
        if (rd !== m_dig[i]) begin errors++; $display("FAIL b2b%0d_dig%0d got %h required %h", n, i, rd, m_dig[i]); end
      end
      wb_read(8'h08, rd);
      checks++;
      if (rd !== m_blkcnt) begin errors++; $display("FAIL b2b%0d_blkcnt got %h required %h", n, rd, m_blkcnt); end
      wb_read(8'h04, rd);
      checks++;
      if (rd !== model_read(8'h04)) begin errors++; $display("FAIL b2b%0d_status got %h required %h", n, rd, model_read(8'h04)); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_abc();
    test_busy();
    test_ready_stall();
    test_byte_lanes();
    test_done_collision();
    test_decode();
    test_back_to_back();
    test_reset_mid_hash();
    test_blkcnt_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog simulation did not complete within 500000 time units");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sha256_wb_ctrl.md
Name: sha256_wb_ctrl

Overview:
- Wishbone slave register front end sitting directly upstream of the SHA-256 compression core inside the user project.
- Firmware on the management SoC loads a 512-bit message block and issues start.
- The block launches the core, captures the 256-bit digest, and raises status and an interrupt.
- Instantiated by the user project wrapper in place of the scratch user logic; drives the core and `user_irq[0]`.

Parameters:
- BASE_ADR, 32'h3000_0000, Wishbone base address; bits [31:8] are decoded.
- DIG_W, 256, digest width; fixed at 256, exists for package reuse only.

Ports:
- wb_clk_i  in  1  single clock for all logic.
- wb_rst_ni  in  1  asynchronous active-low reset; the wrapper drives it as ~wb_rst_i.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte lane selects.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  byte address.
- wbs_ack_o  out  1  single-cycle acknowledge.
- wbs_dat_o  out  32  read data.
- core_start_o  out  1  one-cycle launch pulse to the core.
- core_init_o  out  1  1 = core uses the SHA-256 IV; 0 = core chains from its previous digest.
- core_block_o  out  512  message block; MSG0 drives bits [511:480].
- core_ready_i  in  1  core idle and able to accept start.
- core_digest_valid_i  in  1  one-cycle pulse; digest valid.
- core_digest_i  in  256  digest; H0 is on bits [255:224].
- irq_o  out  1  level interrupt.

Behaviour:
- Reset (async assert, sync release) clears the following:
  - All outputs to 0.
  - MSG and DIGEST registers to 0.
  - CTRL, STATUS and BLKCNT to 0.
  - FSM to IDLE.
- Address selection: a transfer is selected when `stb & cyc` and `adr[31:8] == BASE_ADR[31:8]`. Offset = `adr[7:0]`; `adr[1:0]` is ignored.
- Acknowledge timing:
  - `wbs_ack_o` asserts one cycle after a selected request, for one cycle.
  - No back-to-back ack is issued while `stb` stays high in the ack cycle; the next ack requires a new request cycle.
  - Read data is valid in the ack cycle and is 0 otherwise.
- Register map:
  - 0x00 CTRL: bit0 START, write-1 pulse, always reads 0. Bit1 INIT (RW). Bit2 IRQ_EN (RW).
  - 0x04 STATUS: bit0 BUSY (RO). Bit1 DONE (sticky, write-1-to-clear).
  - 0x08 BLKCNT: RO, 32-bit count of completed blocks; wraps from FFFF_FFFF to 0.
  - 0x40–0x7C MSG0–MSG15: RW, byte writes honour wbs_sel_i.
  - 0x80–0x9C DIG0–DIG7: RO.
  - Any other offset reads 0; writes are acked and ignored.
- Writes to MSG or CTRL.INIT while BUSY=1 are acked and discarded. This keeps core_block_o stable during a hash.
- FSM states and transitions:
  - IDLE: a START write moves to LAUNCH. The same write's INIT bit takes effect for that launch.
  - LAUNCH: when core_ready_i=1, assert core_start_o for exactly one cycle and move to WAIT. If core_ready_i=0, hold in LAUNCH indefinitely.
  - WAIT: on core_digest_valid_i, do all of the following in that cycle, then return to IDLE:
    - Capture core_digest_i into DIG0–7.
    - Set DONE.
    - Increment BLKCNT.
- START written in LAUNCH or WAIT is ignored.
- BUSY = (state != IDLE). DONE is not cleared by a new START.
- core_digest_valid_i outside WAIT is ignored: no capture, no count.
- If digest_valid and a DONE W1C write land in the same cycle, the set wins (DONE=1).
- irq_o = DONE & IRQ_EN, registered; one cycle after DONE/IRQ_EN change.
- Reset mid-hash: FSM returns to IDLE and registers clear. A digest pulse arriving later is ignored.
- core_init_o and core_block_o are direct register outputs, stable from LAUNCH through WAIT.

Decomposition:
- Package sha256_ctrl_pkg holds:
  - Offset localparams: CTRL, STATUS, BLKCNT, MSG_BASE, DIG_BASE.
  - CTRL/STATUS bit index constants.
  - FSM state enum {IDLE, LAUNCH, WAIT}.
  - Word-count constants: 16 message words, 8 digest words.
- One sub-module wb_slave_if handles decode, ack generation and byte-lane write strobes, and exposes a simple reg_we/reg_re/reg_addr/reg_wdata/reg_rdata interface.
- The register file and FSM stay in the top module.

Test Plan:
- Reset-value check:
  - Stimulus: reset, then read 0x00, 0x04, 0x08, 0x40, 0x80.
  - Response: all read 0. ack comes 1 cycle after stb. irq_o=0.
- Single block, "abc" padded:
  - Stimulus: write MSG0=0x61626380, MSG15=0x00000018, other MSG words 0. Write CTRL=0x7 with core_ready_i=1.
  - Response: core_start_o pulses 1 cycle later with core_init_o=1.
  - Stimulus: model returns digest.
  - Response: DIG0=0xBA7816BF, DIG7=0xF20015AD. STATUS=0x2. BLKCNT=1. irq_o=1.
- Busy protection:
  - Stimulus: during WAIT, write MSG3=0xDEADBEEF and CTRL=0x1.
  - Response: both acked. MSG3 unchanged. No second core_start_o. STATUS.BUSY=1.
- Ready stall:
  - Stimulus: hold core_ready_i=0 for 10 cycles after START.
  - Response: core_start_o stays 0 and BUSY=1. Pulse occurs the cycle core_ready_i rises.
- Byte lanes and DONE collision:
  - Stimulus: write MSG1=0xAABBCCDD with sel=4'b0101.
  - Response: MSG1 reads 0x00BB00DD.
  - Stimulus: W1C DONE in the same cycle as core_digest_valid_i.
  - Response: DONE stays 1.
- Reset mid-hash and BLKCNT wrap:
  - Stimulus: assert wb_rst_ni in WAIT, then release and pulse digest_valid.
  - Response: no capture, BLKCNT=0.
  - Stimulus: force BLKCNT=FFFF_FFFF, complete one block.
  - Response: BLKCNT reads 0.
